// File: rtl/slot_frame_packer_pkg.sv
// Shared types and sizing helpers for the slot frame packer.
// Holds the assembly state encoding and the default frame geometry.
package slot_frame_packer_pkg;

    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned WD_DEF    = 4;
    localparam int unsigned NSLOT_DEF = 5;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } asm_state_e;

    // Width needed to count 0..depth frames inclusive.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/slot_frame_packer_if.sv
// Word-in / frame-out bus of the slot frame packer.
// The producer/consumer side uses master, the packer uses slave.
interface slot_frame_packer_if
    import slot_frame_packer_pkg::*;
#(
    parameter int unsigned WD    = WD_DEF,
    parameter int unsigned NSLOT = NSLOT_DEF
);

    logic                  in_valid;
    logic [SLOT_W-1:0]     in_slot;
    logic [WD-1:0]         in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [NSLOT*WD-1:0]   out_frame;
    logic [WD-1:0]         out_chk;

    modport master (
        output in_valid, in_slot, in_data, out_ready,
        input  out_valid, out_frame, out_chk
    );

    modport slave (
        input  in_valid, in_slot, in_data, out_ready,
        output out_valid, out_frame, out_chk
    );

endinterface

// File: rtl/slot_frame_packer_frame_fifo.sv
// First-word-fall-through frame FIFO; a push into a full FIFO succeeds
// only when a pop happens in the same cycle, otherwise it is dropped.
module slot_frame_packer_frame_fifo
    import slot_frame_packer_pkg::*;
#(
    parameter int unsigned EW    = 24,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RSTX,
    input  logic                     push_i,
    input  logic [EW-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic [EW-1:0]            head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [lvl_w(DEPTH)-1:0]  level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = lvl_w(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [LW-1:0] level_q;
    logic          do_pop_c;
    logic          do_push_c;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign head_o    = mem_q[rd_q];
    assign do_pop_c  = pop_i && !empty_o;
    assign do_push_c = push_i && (!full_o || do_pop_c);

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push_c) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (do_pop_c) begin
                rd_q <= rd_q + PW'(1);
            end
            if (do_push_c && !do_pop_c) begin
                level_q <= level_q + LW'(1);
            end else if (do_pop_c && !do_push_c) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/slot_frame_packer.sv
// Collects one rotation of slot-tagged words into a frame with an XOR
// checksum and queues completed frames for a valid/ready consumer.
module slot_frame_packer
    import slot_frame_packer_pkg::*;
#(
    parameter int unsigned WD    = WD_DEF,
    parameter int unsigned NSLOT = NSLOT_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RSTX,
    slot_frame_packer_if.slave       bus,
    output logic                     seq_err,
    output logic                     ovf,
    output logic [lvl_w(DEPTH)-1:0]  fifo_level
);

    localparam int unsigned FW = NSLOT * WD;
    localparam int unsigned EW = FW + WD;
    localparam int unsigned LW = lvl_w(DEPTH);

    asm_state_e          state_q;
    logic [SLOT_W-1:0]   exp_q;
    logic [FW-1:0]       part_q;
    logic [WD-1:0]       chk_q;
    logic                seq_err_q;
    logic                ovf_q;

    logic                complete_c;
    logic                pop_c;
    logic                ovf_c;
    logic [FW-1:0]       push_frame_c;
    logic [WD-1:0]       push_chk_c;
    logic [EW-1:0]       head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LW-1:0]       level;

    // Final slot of a rotation arriving in order completes the frame this cycle.
    always_comb begin
        complete_c   = bus.in_valid && (state_q == COLLECT) &&
                       (bus.in_slot == exp_q) && (exp_q == SLOT_W'(NSLOT - 1));
        push_frame_c = part_q;
        push_frame_c[(NSLOT-1)*WD +: WD] = bus.in_data;
        push_chk_c   = chk_q ^ bus.in_data;
    end

    assign pop_c = !fifo_empty && bus.out_ready;
    assign ovf_c = complete_c && fifo_full && !pop_c;

    // Assembly FSM with registered error pulses.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q   <= HUNT;
            exp_q     <= '0;
            part_q    <= '0;
            chk_q     <= '0;
            seq_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            seq_err_q <= 1'b0;
            ovf_q     <= ovf_c;
            if (bus.in_valid) begin
                case (state_q)
                    HUNT: begin
                        if (bus.in_slot == '0) begin
                            part_q[WD-1:0] <= bus.in_data;
                            chk_q          <= bus.in_data;
                            exp_q          <= SLOT_W'(1);
                            state_q        <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (bus.in_slot == exp_q) begin
                            if (exp_q == SLOT_W'(NSLOT - 1)) begin
                                state_q <= HUNT;
                            end else begin
                                part_q[int'(exp_q)*WD +: WD] <= bus.in_data;
                                chk_q                        <= chk_q ^ bus.in_data;
                                exp_q                        <= exp_q + SLOT_W'(1);
                            end
                        end else begin
                            seq_err_q <= 1'b1;
                            if (bus.in_slot == '0) begin
                                part_q[WD-1:0] <= bus.in_data;
                                chk_q          <= bus.in_data;
                                exp_q          <= SLOT_W'(1);
                            end else begin
                                state_q <= HUNT;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    slot_frame_packer_frame_fifo #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RSTX        (RSTX),
        .push_i      (complete_c),
        .push_data_i ({push_chk_c, push_frame_c}),
        .pop_i       (bus.out_ready),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_frame = head[FW-1:0];
    assign bus.out_chk   = head[EW-1:FW];
    assign seq_err       = seq_err_q;
    assign ovf           = ovf_q;
    assign fifo_level    = level;

endmodule

// File: tb/tb_slot_frame_packer.sv
// Self-checking bench for slot_frame_packer: directed table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_slot_frame_packer;

    localparam int unsigned WD    = 4;
    localparam int unsigned NSLOT = 5;
    localparam int unsigned DEPTH = 4;

    logic       CLK;
    logic       RSTX;
    logic       seq_err;
    logic       ovf;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;

    slot_frame_packer_if #(.WD(WD), .NSLOT(NSLOT)) bus ();

    slot_frame_packer #(.WD(WD), .NSLOT(NSLOT), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RSTX       (RSTX),
        .bus        (bus),
        .seq_err    (seq_err),
        .ovf        (ovf),
        .fifo_level (fifo_level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: words of the attempt in progress, and queued {chk, frame}.
    logic [3:0]  cur [$];
    logic [23:0] mq  [$];

    typedef struct {
        logic       v;
        logic [2:0] s;
        logic [3:0] d;
        logic       ev;
        logic [2:0] el;
        logic       es;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t row(input logic v, input logic [2:0] s, input logic [3:0] d,
                                 input logic ev, input logic [2:0] el, input logic es);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.ev = ev; r.el = el; r.es = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {chk, frame} for a frame whose word k is (base*5 + k) mod 16.
    function automatic logic [23:0] frame_of(input int base);
        logic [19:0] f;
        logic [3:0]  c;
        logic [3:0]  w;
        f = '0;
        c = '0;
        for (int k = 0; k < int'(NSLOT); k++) begin
            w = 4'((base * 5 + k) % 16);
            f[k*4 +: 4] = w;
            c = c ^ w;
        end
        return {c, f};
    endfunction

    function automatic logic [3:0] word_of(input int base, input int k);
        return 4'((base * 5 + k) % 16);
    endfunction

    task automatic model_clear();
        cur.delete();
        mq.delete();
    endtask

    // One clock with the given inputs; model predicts, outputs are checked after the edge.
    task automatic step(input logic v, input logic [2:0] s, input logic [3:0] d, input logic r);
        logic        e_seq;
        logic        e_ovf;
        logic        cpl;
        logic [19:0] cf;
        logic [3:0]  cc;
        bit          pop;
        bus.in_valid  = v;
        bus.in_slot   = s;
        bus.in_data   = d;
        bus.out_ready = r;
        e_seq = 1'b0; e_ovf = 1'b0; cpl = 1'b0; cf = '0; cc = '0;
        if (v) begin
            if (cur.size() == 0) begin
                if (s == 3'd0) cur.push_back(d);
            end else if (int'(s) == cur.size()) begin
                cur.push_back(d);
                if (cur.size() == int'(NSLOT)) begin
                    cpl = 1'b1;
                    for (int k = 0; k < int'(NSLOT); k++) begin
                        cf[k*4 +: 4] = cur[k];
                        cc = cc ^ cur[k];
                    end
                    cur.delete();
                end
            end else begin
                e_seq = 1'b1;
                cur.delete();
                if (s == 3'd0) cur.push_back(d);
            end
        end
        pop = (mq.size() != 0) && r;
        if (pop) void'(mq.pop_front());
        if (cpl) begin
            if (mq.size() < int'(DEPTH)) mq.push_back({cc, cf});
            else e_ovf = 1'b1;
        end
        @(posedge CLK);
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
        chk("seq_err", 64'(seq_err), 64'(e_seq));
        chk("ovf", 64'(ovf), 64'(e_ovf));
        if (mq.size() != 0 && bus.out_valid) begin
            chk("head", 64'({bus.out_chk, bus.out_frame}), 64'(mq[0]));
        end
    endtask

    task automatic send_frame(input int base, input logic r_other, input logic r_last);
        for (int k = 0; k < int'(NSLOT); k++) begin
            step(1'b1, 3'(k), word_of(base, k), (k == int'(NSLOT) - 1) ? r_last : r_other);
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_slot   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        RSTX = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_seq_err", 64'(seq_err), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge CLK);
        RSTX = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int nxt;
        logic [2:0] s;
        logic       v;

        // Directed rows: clean rotation, mid-rotation start, skip, restart on slot 0, out-of-range slot.
        tbl.push_back(row(1, 0, 1, 0, 0, 0));
        tbl.push_back(row(1, 1, 2, 0, 0, 0));
        tbl.push_back(row(1, 2, 3, 0, 0, 0));
        tbl.push_back(row(1, 3, 4, 0, 0, 0));
        tbl.push_back(row(1, 4, 5, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 3, 4'hA, 0, 0, 0));
        tbl.push_back(row(1, 4, 4'hB, 0, 0, 0));
        tbl.push_back(row(1, 0, 1, 0, 0, 0));
        tbl.push_back(row(1, 1, 2, 0, 0, 0));
        tbl.push_back(row(1, 2, 3, 0, 0, 0));
        tbl.push_back(row(1, 3, 4, 0, 0, 0));
        tbl.push_back(row(1, 4, 5, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 0, 1, 0, 0, 0));
        tbl.push_back(row(1, 1, 2, 0, 0, 0));
        tbl.push_back(row(1, 3, 9, 0, 0, 1));
        tbl.push_back(row(1, 0, 1, 0, 0, 0));
        tbl.push_back(row(1, 1, 2, 0, 0, 0));
        tbl.push_back(row(1, 2, 3, 0, 0, 0));
        tbl.push_back(row(1, 3, 4, 0, 0, 0));
        tbl.push_back(row(1, 4, 5, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 0, 7, 0, 0, 0));
        tbl.push_back(row(1, 1, 7, 0, 0, 0));
        tbl.push_back(row(1, 0, 1, 0, 0, 1));
        tbl.push_back(row(1, 1, 2, 0, 0, 0));
        tbl.push_back(row(1, 2, 3, 0, 0, 0));
        tbl.push_back(row(1, 3, 4, 0, 0, 0));
        tbl.push_back(row(1, 4, 5, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 0, 1, 0, 0, 0));
        tbl.push_back(row(1, 6, 3, 0, 0, 1));
        tbl.push_back(row(1, 1, 2, 0, 0, 0));

        do_reset();
        foreach (tbl[i]) begin
            bus.in_valid  = tbl[i].v;
            bus.in_slot   = tbl[i].s;
            bus.in_data   = tbl[i].d;
            bus.out_ready = 1'b1;
            @(posedge CLK);
            #1;
            chk("tbl_out_valid", 64'(bus.out_valid), 64'(tbl[i].ev));
            chk("tbl_level", 64'(fifo_level), 64'(tbl[i].el));
            chk("tbl_seq_err", 64'(seq_err), 64'(tbl[i].es));
            chk("tbl_ovf", 64'(ovf), 64'd0);
            if (tbl[i].ev) begin
                chk("tbl_frame", 64'(bus.out_frame), 64'h54321);
                chk("tbl_chk", 64'(bus.out_chk), 64'h1);
            end
        end

        // Backpressure: four frames fill the FIFO, the fifth is dropped.
        do_reset();
        for (int b = 1; b <= 5; b++) begin
            send_frame(b, 1'b0, 1'b0);
            if (b == 4) chk("bp_level_full", 64'(fifo_level), 64'd4);
        end
        chk("bp_ovf_on_fifth", 64'(ovf), 64'd1);
        chk("bp_level_after_drop", 64'(fifo_level), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("bp_drain_order", 64'({bus.out_chk, bus.out_frame}), 64'(frame_of(i)));
            step(1'b0, 3'd0, 4'd0, 1'b1);
        end
        chk("bp_level_drained", 64'(fifo_level), 64'd0);

        // Full FIFO with a pop in the same cycle as a completion.
        for (int b = 6; b <= 9; b++) send_frame(b, 1'b0, 1'b0);
        send_frame(10, 1'b0, 1'b1);
        chk("fullpop_no_ovf", 64'(ovf), 64'd0);
        chk("fullpop_level", 64'(fifo_level), 64'd4);
        for (int i = 7; i <= 10; i++) begin
            chk("fullpop_order", 64'({bus.out_chk, bus.out_frame}), 64'(frame_of(i)));
            step(1'b0, 3'd0, 4'd0, 1'b1);
        end
        chk("fullpop_drained", 64'(fifo_level), 64'd0);

        // Push and pop together at level 1.
        send_frame(11, 1'b0, 1'b0);
        send_frame(12, 1'b0, 1'b1);
        chk("lvl1_level", 64'(fifo_level), 64'd1);
        chk("lvl1_head", 64'({bus.out_chk, bus.out_frame}), 64'(frame_of(12)));

        // Asynchronous reset in the middle of a frame with a frame queued.
        step(1'b1, 3'd0, 4'd1, 1'b0);
        step(1'b1, 3'd1, 4'd2, 1'b0);
        step(1'b1, 3'd2, 4'd3, 1'b0);
        #2;
        RSTX = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_level", 64'(fifo_level), 64'd0);
        chk("async_rst_seq_err", 64'(seq_err), 64'd0);
        chk("async_rst_ovf", 64'(ovf), 64'd0);
        @(negedge CLK);
        RSTX = 1'b1;
        @(posedge CLK);
        #1;
        step(1'b1, 3'd3, 4'd4, 1'b1);
        step(1'b1, 3'd4, 4'd5, 1'b1);
        chk("post_rst_ignored", 64'(bus.out_valid), 64'd0);
        for (int k = 0; k < 5; k++) step(1'b1, 3'(k), 4'(k + 1), 1'b0);
        chk("post_rst_level", 64'(fifo_level), 64'd1);
        chk("post_rst_frame", 64'(bus.out_frame), 64'h54321);
        chk("post_rst_chk", 64'(bus.out_chk), 64'h1);

        // Randomized traffic: mostly in-order rotations with injected faults.
        do_reset();
        nxt = 0;
        for (int n = 0; n < 4000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 88) s = 3'(nxt);
            else s = 3'($urandom_range(0, 7));
            if (v) nxt = (int'(s) + 1) % int'(NSLOT);
            step(v, s, 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_frame_packer.md
Name: slot_frame_packer

Overview:
- Downstream of the round-robin substitution stage. Each cycle that stage emits one transformed WD-bit word, tagged with its 0..4 slot index from the rotation counter.
- This block collects one full rotation, slots 0..NSLOT-1, into a single frame and attaches an XOR checksum.
- Completed frames are buffered in a small FIFO and presented on a valid/ready output to the consumer.
- Discontinuities in the slot sequence and FIFO overflow are flagged.

Parameters:
- WD, 4, width of one data word.
- NSLOT, 5, words per frame; equals the upstream rotation length.
- DEPTH, 4, FIFO depth in frames; power of 2, >= 2.

Ports:
- CLK  in  1  clock.
- RSTX  in  1  asynchronous active-low reset.
- in_valid  in  1  in_slot/in_data are valid this cycle; there is no backpressure upstream.
- in_slot  in  3  slot index of in_data.
- in_data  in  WD  transformed word.
- out_valid  out  1  FIFO head holds a frame.
- out_ready  in  1  consumer accepts the head frame.
- out_frame  out  NSLOT*WD  head frame; slot k occupies bits [k*WD +: WD].
- out_chk  out  WD  XOR of the NSLOT words of the head frame.
- seq_err  out  1  one-cycle pulse on a slot-sequence violation.
- ovf  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- fifo_level  out  clog2(DEPTH+1)  number of frames held.

Behaviour:
- Reset state: all outputs 0, assembly FSM in HUNT, FIFO empty, partial frame and running checksum cleared. Reset takes effect immediately regardless of state.
- Only cycles with in_valid=1 are evaluated; an idle cycle leaves all state unchanged.
- FSM HUNT:
  - in_slot==0: store the word in position 0, load chk=in_data, set exp=1, go to COLLECT.
  - Any other slot: ignore the word, no seq_err.
- FSM COLLECT with expected slot exp:
  - in_slot==exp and exp<NSLOT-1: store the word in position exp, chk^=in_data, exp+1.
  - in_slot==exp==NSLOT-1: the frame is complete; push {frame, chk^in_data} to the FIFO and go to HUNT.
  - in_slot!=exp, including any value >=NSLOT: seq_err=1 for that cycle and the partial frame is discarded.
    - If in_slot==0, restart COLLECT with this word as position 0 (chk=in_data, exp=1).
    - Otherwise go to HUNT.
- Latency: a frame completed in cycle t shows out_valid=1 at t+1 when the FIFO was empty.
- FIFO is first-word-fall-through:
  - out_valid = (level!=0); out_frame/out_chk show the head entry.
  - A pop occurs on out_valid & out_ready.
  - Push while full with no pop: frame dropped, ovf=1 for one cycle, contents unchanged.
  - Push while full with a simultaneous pop: both occur, level stays DEPTH, no ovf.
  - Push and pop at level 1: the old head leaves, the new frame becomes head, level stays 1.
  - Pointers wrap modulo DEPTH; level saturates at 0 and DEPTH.
- out_frame/out_chk are don't-care when out_valid=0; the bench must not check them then.
- Checksum is a plain bitwise XOR of the words, no carry.

Decomposition:
- Shared package:
  - assembly state enum {HUNT, COLLECT}.
  - SLOT_W=3 and the NSLOT default.
  - Helper function for level width, clog2(DEPTH+1).
- One natural sub-module, frame_fifo:
  - Parameterised by entry width (NSLOT*WD+WD) and DEPTH.
  - push/pop/full/empty/level, FWFT, with the simultaneous push+pop-when-full rule above.
- The top holds the FSM, partial-frame register, checksum and error pulses.

Test Plan:
- Clean rotation: slots 0..4 with data 1,2,3,4,5, out_ready=1 -> one cycle after slot 4: out_valid=1, out_frame=0x54321, out_chk=0x1, seq_err never asserted.
- Mid-rotation start: slots 3,4,0,1,2,3,4 with data 0xA,0xB,1,2,3,4,5 -> the first two words are ignored with no seq_err; a single frame 0x54321 is produced.
- Skip: slots 0,1,3,0,1,2,3,4 -> seq_err pulses in the slot-3 cycle only, no frame from the first attempt, one frame from the second.
- Error restart on slot 0: slots 0,1,0,1,2,3,4 with data 7,7,1,2,3,4,5 -> seq_err on the third word, and that word starts the frame; output is 0x54321.
- Backpressure with out_ready=0, 5 complete frames with distinct data:
  - fifo_level reaches 4; ovf pulses on the 5th completion.
  - Then out_ready=1 drains frames 1-4 in order and level returns to 0.
  - Repeat with a full FIFO, out_ready=1 and a completion in the same cycle -> no ovf, level stays 4, the new frame is last in order.
- Reset mid-frame: RSTX low after slots 0,1,2 -> all outputs 0 immediately. After release, slots 3,4 are ignored and the next clean rotation alone appears.
